// File: rtl/start_sequencer.sv
// Queues start requests and launches one downstream F->G handshake at a time.
// Each wait state has its own timeout; F and G seen high together abort the sequence.
module start_sequencer #(
   parameter int CNT_W   = 4,
   parameter int TIMEOUT = 8
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Req,
   input  logic             Clr,
   input  logic             F,
   input  logic             G,
   output logic             Start,
   output logic [CNT_W-1:0] Pending,
   output logic             Busy,
   output logic             Done,
   output logic             Overflow,
   output logic             Error
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] PEND_MAX = '1;

   typedef enum logic [1:0] {IDLE, WAIT_F, WAIT_G, WAIT_END} state_t;

   state_t           state_q, state_d, adv_state;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic [CNT_W-1:0] pend_q, pend_d;
   logic             start_q, start_d;
   logic             done_q, done_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;
   logic             viol, launch, advance, err_set, ovf_set;

   always_comb begin
      state_d   = state_q;
      tmo_d     = tmo_q;
      pend_d    = pend_q;
      done_d    = 1'b0;
      err_set   = 1'b0;
      ovf_set   = 1'b0;
      advance   = 1'b0;
      adv_state = IDLE;
      viol      = F & G;
      launch    = (state_q == IDLE) && (pend_q != '0) && !viol;
      start_d   = launch;

      case (state_q)
         WAIT_F:   begin advance = F;  adv_state = WAIT_G;   end
         WAIT_G:   begin advance = G;  adv_state = WAIT_END; end
         WAIT_END: begin advance = !G; adv_state = IDLE;     end
         default:  begin advance = 1'b0; adv_state = IDLE;   end
      endcase

      // A protocol violation outranks progress and timeout in every state.
      if (viol) begin
         err_set = 1'b1;
         state_d = IDLE;
         tmo_d   = '0;
      end else if (state_q == IDLE) begin
         if (launch) begin
            state_d = WAIT_F;
            tmo_d   = '0;
         end
      end else if (advance) begin
         state_d = adv_state;
         tmo_d   = '0;
         done_d  = (state_q == WAIT_END);
      end else if (tmo_q == TMO_LAST) begin
         err_set = 1'b1;
         state_d = IDLE;
         tmo_d   = '0;
      end else begin
         tmo_d = tmo_q + 1'b1;
      end

      // A request coinciding with a launch leaves the count unchanged.
      if (Req && !launch) begin
         if (pend_q == PEND_MAX) ovf_set = 1'b1;
         else                    pend_d  = pend_q + 1'b1;
      end else if (!Req && launch) begin
         pend_d = pend_q - 1'b1;
      end

      ovf_d = ovf_set | (ovf_q & ~Clr);
      err_d = err_set | (err_q & ~Clr);
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         tmo_q   <= '0;
         pend_q  <= '0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         pend_q  <= pend_d;
         start_q <= start_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         err_q   <= err_d;
      end
   end

   assign Start    = start_q;
   assign Pending  = pend_q;
   assign Busy     = (state_q != IDLE);
   assign Done     = done_q;
   assign Overflow = ovf_q;
   assign Error    = err_q;
endmodule

// File: tb/tb_start_sequencer.sv
// Directed scenarios plus randomized traffic for start_sequencer, checked every
// cycle against a sequence-level reference model.
module tb_start_sequencer;
   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 8;
   localparam int PMAX    = (1 << CNT_W) - 1;

   logic             Clock = 1'b0;
   logic             Reset = 1'b1;
   logic             Req = 1'b0, Clr = 1'b0, F = 1'b0, G = 1'b0;
   logic             Start, Busy, Done, Overflow, Error;
   logic [CNT_W-1:0] Pending;

   start_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .Clock(Clock), .Reset(Reset), .Req(Req), .Clr(Clr), .F(F), .G(G),
      .Start(Start), .Pending(Pending), .Busy(Busy), .Done(Done),
      .Overflow(Overflow), .Error(Error)
   );

   always #5 Clock = ~Clock;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: phase 0 idle, 1 awaiting F, 2 awaiting G, 3 awaiting G release.
   int m_phase, m_wait, m_pend;
   bit m_start, m_done, m_ovf, m_err;
   // Downstream behaviour: 0 conforming, 1 silent, 2 random noise, 3 driven by hand.
   int ds_mode = 0;
   bit h1, h2;

   task automatic model_reset();
      m_phase = 0; m_wait = 0; m_pend = 0;
      m_start = 0; m_done = 0; m_ovf = 0; m_err = 0;
   endtask

   task automatic model_step();
      bit viol, launch, adv, err_set;
      int p;
      viol    = F && G;
      launch  = (m_phase == 0) && (m_pend > 0) && !viol;
      err_set = viol;
      adv     = (m_phase == 1 && F) || (m_phase == 2 && G) || (m_phase == 3 && !G);
      m_done  = 0;
      m_start = launch;
      if (viol) m_phase = 0;
      else if (m_phase == 0) begin
         if (launch) begin m_phase = 1; m_wait = 0; end
      end else if (adv) begin
         m_done  = (m_phase == 3);
         m_phase = (m_phase + 1) % 4;
         m_wait  = 0;
      end else begin
         m_wait++;
         if (m_wait >= TIMEOUT) begin err_set = 1; m_phase = 0; end
      end
      p      = m_pend + int'(Req) - int'(launch);
      m_ovf  = (p > PMAX) || (m_ovf && !Clr);
      m_pend = (p > PMAX) ? PMAX : p;
      m_err  = err_set || (m_err && !Clr);
   endtask

   task automatic drive_ds();
      case (ds_mode)
         0: begin F = h1; G = h2; end
         1: begin F = 1'b0; G = 1'b0; end
         2: begin F = ($urandom_range(0, 2) == 0); G = ($urandom_range(0, 2) == 0); end
         default: ;
      endcase
      h2 = h1;
      h1 = m_start;
   endtask

   task automatic compare_all();
      check("start",    int'(Start),    int'(m_start));
      check("done",     int'(Done),     int'(m_done));
      check("busy",     int'(Busy),     int'(m_phase != 0));
      check("pending",  int'(Pending),  m_pend);
      check("overflow", int'(Overflow), int'(m_ovf));
      check("error",    int'(Error),    int'(m_err));
   endtask

   task automatic tick();
      drive_ds();
      model_step();
      @(posedge Clock);
      #1;
      compare_all();
   endtask

   // Reset is asserted mid-cycle so its asynchronous effect is visible before any edge.
   task automatic do_reset();
      #2 Reset = 1'b0;
      #1;
      model_reset();
      compare_all();
      Req = 1'b0; Clr = 1'b0; F = 1'b0; G = 1'b0; h1 = 0; h2 = 0;
      @(negedge Clock);
      Reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int starts, dones, peak, last_e, n_start;
      model_reset();
      #1;

      // Single request, conforming downstream.
      do_reset();
      check("rst_pending", int'(Pending), 0);
      check("rst_busy", int'(Busy), 0);
      ds_mode = 0;
      Req = 1'b1; tick();
      check("s1_pending_e1", int'(Pending), 1);
      Req = 1'b0; tick();
      check("s1_start_e2", int'(Start), 1);
      check("s1_pending_e2", int'(Pending), 0);
      repeat (3) tick();
      check("s1_nodone_e5", int'(Done), 0);
      tick();
      check("s1_done_e6", int'(Done), 1);
      check("s1_idle_e6", int'(Busy), 0);

      // Three back-to-back requests.
      do_reset();
      starts = 0; dones = 0; peak = 0; last_e = -1;
      for (int e = 1; e <= 23; e++) begin
         Req = (e <= 3);
         tick();
         if (int'(Pending) > peak) peak = int'(Pending);
         if (Done) dones++;
         if (Start) begin
            if (last_e >= 0) check("s3_start_gap", e - last_e, 5);
            last_e = e;
            starts++;
         end
      end
      check("s3_starts", starts, 3);
      check("s3_dones", dones, 3);
      check("s3_peak", peak, 2);
      check("s3_ovf", int'(Overflow), 0);

      // Saturation against a stalled downstream, then clear.
      do_reset();
      ds_mode = 1;
      Req = 1'b1;
      repeat (24) tick();
      check("sat_pending", int'(Pending), 15);
      check("sat_ovf", int'(Overflow), 1);
      Req = 1'b0; Clr = 1'b1; tick();
      Clr = 1'b0;
      check("clr_pending", int'(Pending), 15);
      check("clr_ovf", int'(Overflow), 0);

      // F never arrives: timeout in the first wait state.
      do_reset();
      ds_mode = 1;
      Req = 1'b1; tick();
      Req = 1'b0;
      repeat (8) tick();
      check("tmo_err_e9", int'(Error), 0);
      check("tmo_busy_e9", int'(Busy), 1);
      tick();
      check("tmo_err_e10", int'(Error), 1);
      check("tmo_busy_e10", int'(Busy), 0);
      check("tmo_nodone", int'(Done), 0);

      // F and G together while waiting for G, then the next request launches.
      do_reset();
      ds_mode = 3; F = 1'b0; G = 1'b0;
      Req = 1'b1; tick(); tick();
      Req = 1'b0; F = 1'b1; tick();
      check("viol_busy_e3", int'(Busy), 1);
      G = 1'b1; tick();
      check("viol_err", int'(Error), 1);
      check("viol_idle", int'(Busy), 0);
      F = 1'b0; G = 1'b0; tick();
      check("viol_relaunch", int'(Start), 1);
      check("viol_pending", int'(Pending), 0);

      // Reset in the middle of a sequence discards queued work.
      do_reset();
      ds_mode = 0;
      Req = 1'b1; repeat (4) tick();
      Req = 1'b0;
      check("mrst_pending_pre", int'(Pending), 3);
      do_reset();
      check("mrst_pending", int'(Pending), 0);
      check("mrst_busy", int'(Busy), 0);
      n_start = 0;
      repeat (10) begin tick(); if (Start) n_start++; end
      check("mrst_no_start", n_start, 0);
      Req = 1'b1; tick();
      Req = 1'b0; tick();
      check("mrst_new_start", int'(Start), 1);

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) ds_mode = (c % 400 == 0) ? 0 : int'($urandom_range(0, 2));
         if ($urandom_range(0, 399) == 0) do_reset();
         Req = ($urandom_range(0, 2) == 0);
         Clr = ($urandom_range(0, 9) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/start_sequencer.md
START_SEQUENCER -- requirements
Module: start_sequencer

Interface
REQ-001 Parameter CNT_W, default 4: width of pending-request counter; max count 2^CNT_W-1.
REQ-002 Parameter TIMEOUT, default 8: max cycles allowed in any wait state before abort.
REQ-003 Clock  input  1  single clock; all state updates on posedge Clock.
REQ-004 Reset  input  1  asynchronous, active-low reset; Reset=0 forces reset state immediately, independent of Clock.
REQ-005 Req  input  1  request pulse; each cycle sampled high queues one sequence.
REQ-006 Clr  input  1  synchronous clear of sticky flags Overflow and Error.
REQ-007 F  input  1  downstream sequencer phase-1 indicator.
REQ-008 G  input  1  downstream sequencer phase-2 indicator.
REQ-009 Start  output  1  registered one-cycle launch pulse to downstream sequencer.
REQ-010 Pending  output  CNT_W  queued requests not yet launched.
REQ-011 Busy  output  1  high in any state other than IDLE.
REQ-012 Done  output  1  registered one-cycle pulse on completed F->G sequence.
REQ-013 Overflow  output  1  sticky: Req dropped at full count.
REQ-014 Error  output  1  sticky: timeout or protocol violation.

Function
REQ-015 States SHALL be IDLE, WAIT_F, WAIT_G, WAIT_END; Busy SHALL equal (state != IDLE).
REQ-016 IDLE with Pending>0: next edge SHALL set Start=1, decrement Pending, enter WAIT_F.
REQ-017 Start SHALL be high for exactly one cycle per launch; never high outside the cycle following an IDLE launch edge.
REQ-018 WAIT_F: F=1 sampled SHALL move to WAIT_G.
REQ-019 WAIT_G: G=1 sampled SHALL move to WAIT_END.
REQ-020 WAIT_END: G=0 sampled SHALL set Done=1 for one cycle and return to IDLE.
REQ-021 Next launch SHALL occur no earlier than the edge after return to IDLE (no back-to-back Start).
REQ-022 Per-state timeout counter SHALL clear on each state entry; reaching TIMEOUT cycles in a wait state SHALL set Error, return to IDLE, no Done.
REQ-023 F=1 and G=1 sampled together in any state SHALL set Error and return to IDLE, no Done.
REQ-024 Req with no launch this edge: Pending+1; Req with launch same edge: Pending unchanged.
REQ-025 Req at Pending=max with no launch SHALL leave Pending at max and set Overflow.
REQ-026 Pending SHALL never wrap below 0 or above max.
REQ-027 Aborted (error) sequence SHALL NOT be re-queued; remaining Pending launches normally afterward.
REQ-028 Clr=1 SHALL clear Overflow and Error next edge; a set condition in the same cycle SHALL win (flag stays 1).
REQ-029 Latency: Req into empty idle block at edge k -> Start high after edge k+1.
REQ-030 Nominal sequence against a conforming downstream: Start pulse to Done pulse = 4 cycles.

Reset
REQ-031 Reset=0 SHALL asynchronously force state IDLE, Pending=0, Start=0, Done=0, Overflow=0, Error=0, timeout counter 0.
REQ-032 Reset asserted mid-sequence SHALL abandon the sequence with no Done and discard all pending requests.
REQ-033 First launch after Reset release SHALL require a new Req.

Verification
REQ-034 Single Req at edge 1 with conforming downstream -> Start high after edge 2, Done high after edge 6, Pending 1->0, Busy low after edge 6.
REQ-035 Three Req on consecutive edges -> Pending peaks at 2, exactly three Start pulses each 5 cycles apart, three Done pulses, Overflow=0.
REQ-036 CNT_W=4, 16 Req while first sequence stalled -> Pending saturates at 15, Overflow=1; Clr -> Overflow=0, Pending unchanged.
REQ-037 Downstream never raises F after Start -> Error=1 after TIMEOUT=8 cycles in WAIT_F, state IDLE, no Done.
REQ-038 F=G=1 injected in WAIT_G -> Error=1, IDLE next edge, next pending request launches normally.
REQ-039 Reset=0 pulsed mid-edge in WAIT_G with Pending=3 -> all outputs 0 immediately, no Start after release until a new Req.
